spo2_window_stats: RTL and testbench

- Receive side of the LED/ADC sampling interface driven by the front-end controller.
- Demultiplexes the alternating RED and IR ADC samples using the LED phase lines.
- Accumulates per-channel DC (mean) and AC (peak-to-peak) over a fixed window of sample pairs, and detects IR pulse beats to report beat interval.
- Outputs feed the SpO2 ratio and heart-rate arithmetic block downstream.

---
 rtl/spo2_pkg.sv | 38 +++
 rtl/chan_accum.sv | 64 ++++++
 rtl/spo2_window_stats.sv | 250 +++++++++++++++++++++++++
 tb/tb_spo2_window_stats.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spo2_pkg.sv
// ---------------------------------------------------------------------------
// spo2_pkg
// Shared definitions for the SpO2 window-statistics receive path:
//   - ADC sample width and the default window length exponent
//   - window FSM and beat-detector state encodings
//   - sat_adc(): clamps a signed threshold into the ADC code range
// ---------------------------------------------------------------------------
package spo2_pkg;

  localparam int ADC_W        = 8;
  localparam int ADC_MAX      = (1 << ADC_W) - 1;
  localparam int WIN_LOG2_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_REPORT
  } win_state_e;

  typedef enum logic {
    BEAT_UNARMED,
    BEAT_LOW
  } beat_state_e;

  // Thresholds are DC +/- HYST, which can leave the 0..255 code range.
  function automatic logic [ADC_W-1:0] sat_adc(input int value);
    int clamped;
    if (value < 0) begin
      clamped = 0;
    end else if (value > ADC_MAX) begin
      clamped = ADC_MAX;
    end else begin
      clamped = value;
    end
    return clamped[ADC_W-1:0];
  endfunction

endpackage

// File: rtl/chan_accum.sv
// ---------------------------------------------------------------------------
// chan_accum
// Per-channel window accumulator: running sum, minimum and maximum of the
// samples presented with sample_valid. clear restarts the window; a sample
// arriving together with clear becomes the first sample of the new window.
// Ports:
//   CLK, rst      clock, synchronous active-high reset
//   clear         restart the window
//   sample_valid  data holds a sample to accumulate
//   data          ADC sample
//   dc            sum >> WIN_LOG2 (window mean, truncated)
//   ac            max - min over the window
// ---------------------------------------------------------------------------
module chan_accum
  import spo2_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] data,
  output logic [ADC_W-1:0] dc,
  output logic [ADC_W-1:0] ac
);

  // 2^WIN_LOG2 samples of at most 255 always fit in ADC_W + WIN_LOG2 bits.
  localparam int SUM_W = ADC_W + WIN_LOG2;

  logic [SUM_W-1:0] sum_q;
  logic [ADC_W-1:0] min_q;
  logic [ADC_W-1:0] max_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples its inputs from before the clock edge.
  always_ff @(posedge CLK) begin
    if (rst) begin
      sum_q <= '0;
      min_q <= '1;
      max_q <= '0;
    end else if (clear) begin
      if (sample_valid) begin
        sum_q <= SUM_W'(data);
        min_q <= data;
        max_q <= data;
      end else begin
        sum_q <= '0;
        min_q <= '1;
        max_q <= '0;
      end
    end else if (sample_valid) begin
      sum_q <= sum_q + SUM_W'(data);
      if (data < min_q) min_q <= data;
      if (data > max_q) max_q <= data;
    end
  end

  // Dropping the low WIN_LOG2 bits is the divide by the window length.
  assign dc = sum_q[SUM_W-1 -: ADC_W];
  // An empty window (min=255, max=0) reads as zero swing.
  assign ac = (max_q >= min_q) ? (max_q - min_q) : '0;

endmodule

// File: rtl/spo2_window_stats.sv
// ---------------------------------------------------------------------------
// spo2_window_stats
// Receive side of the LED/ADC sampling interface. Falling edges of the LED
// phase lines mark RED and IR samples; RED-then-IR pairs are accumulated over
// 2^WIN_LOG2 pairs to report per-channel DC (mean) and AC (max-min). IR
// samples also drive a hysteretic beat detector that reports beat interval.
// Ports:
//   CLK, rst                      clock, synchronous active-high reset
//   Enable                        run; low discards the window in progress
//   LED_RED, LED_IR               controller LED phase lines
//   RED_ADC_Value, IR_ADC_Value   samples, valid at the end of each phase
//   RED_DC/RED_AC/IR_DC/IR_AC     window statistics, held between reports
//   Stats_Valid                   one-cycle pulse when the statistics update
//   Beat                          one-cycle pulse per detected IR beat
//   Beat_Interval                 pairs between the last two beats
//   Phase_Err                     sticky: both LED phases seen high together
// ---------------------------------------------------------------------------
module spo2_window_stats
  import spo2_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int HYST     = 8,
  parameter int IBI_MAX  = 255
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             Enable,
  input  logic             LED_RED,
  input  logic             LED_IR,
  input  logic [ADC_W-1:0] RED_ADC_Value,
  input  logic [ADC_W-1:0] IR_ADC_Value,
  output logic [ADC_W-1:0] RED_DC,
  output logic [ADC_W-1:0] RED_AC,
  output logic [ADC_W-1:0] IR_DC,
  output logic [ADC_W-1:0] IR_AC,
  output logic             Stats_Valid,
  output logic             Beat,
  output logic [ADC_W-1:0] Beat_Interval,
  output logic             Phase_Err
);

  localparam int                CNT_W     = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0]  WIN_PAIRS = CNT_W'(1 << WIN_LOG2);
  localparam logic [ADC_W-1:0]  IBI_SAT   = ADC_W'(IBI_MAX);

  // ---------------- phase edge detect and pairing ----------------
  logic             led_red_q;
  logic             led_ir_q;
  logic             phase_err_q;
  logic             red_pend_q;
  logic [ADC_W-1:0] red_hold_q;
  logic             ev_blocked;
  logic             red_evt;
  logic             ir_evt;
  logic             pair_valid;

  // Falls leaving a cycle where both phases were high come from a corrupted
  // phase sequence, so neither is taken as a sample.
  assign ev_blocked = (led_red_q & led_ir_q) | (LED_RED & LED_IR);
  assign red_evt    = led_red_q & ~LED_RED & ~ev_blocked;
  assign ir_evt     = led_ir_q  & ~LED_IR  & ~ev_blocked;
  // An IR sample completes a pair only if a RED sample is waiting.
  assign pair_valid = ir_evt & red_pend_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      led_red_q   <= 1'b0;
      led_ir_q    <= 1'b0;
      phase_err_q <= 1'b0;
      red_pend_q  <= 1'b0;
      red_hold_q  <= '0;
    end else begin
      led_red_q <= LED_RED;
      led_ir_q  <= LED_IR;
      if (LED_RED && LED_IR) phase_err_q <= 1'b1;
      if (red_evt) begin
        // A newer RED sample replaces one still waiting for its IR partner.
        red_pend_q <= 1'b1;
        red_hold_q <= RED_ADC_Value;
      end else if (ir_evt) begin
        red_pend_q <= 1'b0;
      end
    end
  end

  // ---------------- window FSM ----------------
  win_state_e       state_q;
  win_state_e       state_d;
  logic [CNT_W-1:0] pair_cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             acc_clear;
  logic             acc_valid;
  logic             report;

  assign cnt_inc   = pair_cnt_q + CNT_W'(1);
  assign acc_valid = pair_valid & Enable & (state_q != ST_IDLE);
  assign report    = (state_q == ST_REPORT);

  always_ff @(posedge CLK) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        acc_clear = 1'b1;
        if (Enable) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (acc_valid && (cnt_inc == WIN_PAIRS)) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        acc_clear = 1'b1;
        state_d   = ST_FILL;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!Enable) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      pair_cnt_q <= '0;
    end else if (acc_clear) begin
      // A pair landing on the REPORT cycle opens the next window.
      pair_cnt_q <= acc_valid ? CNT_W'(1) : '0;
    end else if (acc_valid) begin
      pair_cnt_q <= cnt_inc;
    end
  end

  // ---------------- channel accumulators ----------------
  logic [ADC_W-1:0] red_dc_acc;
  logic [ADC_W-1:0] red_ac_acc;
  logic [ADC_W-1:0] ir_dc_acc;
  logic [ADC_W-1:0] ir_ac_acc;

  chan_accum #(.WIN_LOG2(WIN_LOG2)) u_red_accum (
    .CLK          (CLK),
    .rst          (rst),
    .clear        (acc_clear),
    .sample_valid (acc_valid),
    .data         (red_hold_q),
    .dc           (red_dc_acc),
    .ac           (red_ac_acc)
  );

  chan_accum #(.WIN_LOG2(WIN_LOG2)) u_ir_accum (
    .CLK          (CLK),
    .rst          (rst),
    .clear        (acc_clear),
    .sample_valid (acc_valid),
    .data         (IR_ADC_Value),
    .dc           (ir_dc_acc),
    .ac           (ir_ac_acc)
  );

  // ---------------- reported statistics ----------------
  logic [ADC_W-1:0] red_dc_q;
  logic [ADC_W-1:0] red_ac_q;
  logic [ADC_W-1:0] ir_dc_q;
  logic [ADC_W-1:0] ir_ac_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      red_dc_q <= '0;
      red_ac_q <= '0;
      ir_dc_q  <= '0;
      ir_ac_q  <= '0;
    end else if (report) begin
      red_dc_q <= red_dc_acc;
      red_ac_q <= red_ac_acc;
      ir_dc_q  <= ir_dc_acc;
      ir_ac_q  <= ir_ac_acc;
    end
  end

  // The finished window is shown directly during REPORT so the statistics
  // and Stats_Valid appear in the same cycle; the registers then hold them.
  assign RED_DC      = report ? red_dc_acc : red_dc_q;
  assign RED_AC      = report ? red_ac_acc : red_ac_q;
  assign IR_DC       = report ? ir_dc_acc  : ir_dc_q;
  assign IR_AC       = report ? ir_ac_acc  : ir_ac_q;
  assign Stats_Valid = report;
  assign Phase_Err   = phase_err_q;

  // ---------------- beat detector ----------------
  beat_state_e      beat_q;
  logic             beat_pulse_q;
  logic             reported_q;
  logic             beat_seen_q;
  logic [ADC_W-1:0] ibi_cnt_q;
  logic [ADC_W-1:0] ibi_q;
  logic [ADC_W-1:0] ibi_next;
  logic [ADC_W-1:0] lo_thr;
  logic [ADC_W-1:0] hi_thr;
  logic             beat_eval;
  logic             beat_hit;

  assign lo_thr    = sat_adc(int'(ir_dc_q) - HYST);
  assign hi_thr    = sat_adc(int'(ir_dc_q) + HYST);
  // Thresholds are meaningless until a window has produced an IR DC level.
  assign beat_eval = ir_evt & reported_q;
  assign beat_hit  = beat_eval & (beat_q == BEAT_LOW) & (IR_ADC_Value > hi_thr);
  // The interval includes the pair that carries the beat itself.
  assign ibi_next  = (pair_valid && (ibi_cnt_q != IBI_SAT)) ? ibi_cnt_q + 1'b1 : ibi_cnt_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      beat_q       <= BEAT_UNARMED;
      beat_pulse_q <= 1'b0;
      reported_q   <= 1'b0;
      beat_seen_q  <= 1'b0;
      ibi_cnt_q    <= '0;
      ibi_q        <= '0;
    end else begin
      beat_pulse_q <= 1'b0;
      if (!Enable) begin
        beat_q      <= BEAT_UNARMED;
        reported_q  <= 1'b0;
        beat_seen_q <= 1'b0;
        ibi_cnt_q   <= '0;
      end else begin
        if (report) reported_q <= 1'b1;
        if (beat_eval && (beat_q == BEAT_UNARMED) && (IR_ADC_Value < lo_thr)) begin
          beat_q <= BEAT_LOW;
        end
        if (beat_hit) begin
          beat_q       <= BEAT_UNARMED;
          beat_pulse_q <= 1'b1;
          beat_seen_q  <= 1'b1;
          // The first beat after enable has no predecessor to measure from.
          if (beat_seen_q) ibi_q <= ibi_next;
          ibi_cnt_q <= '0;
        end else begin
          ibi_cnt_q <= ibi_next;
        end
      end
    end
  end

  assign Beat          = beat_pulse_q;
  assign Beat_Interval = ibi_q;

endmodule

// File: tb/tb_spo2_window_stats.sv
// ---------------------------------------------------------------------------
// tb_spo2_window_stats
// Directed bench for spo2_window_stats with WIN_LOG2=2 (4-pair windows),
// HYST=8, IBI_MAX=255. Inputs are driven and outputs sampled on the falling
// clock edge; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_spo2_window_stats;

  logic       CLK = 1'b0;
  logic       rst;
  logic       Enable;
  logic       LED_RED;
  logic       LED_IR;
  logic [7:0] RED_ADC_Value;
  logic [7:0] IR_ADC_Value;
  logic [7:0] RED_DC;
  logic [7:0] RED_AC;
  logic [7:0] IR_DC;
  logic [7:0] IR_AC;
  logic       Stats_Valid;
  logic       Beat;
  logic [7:0] Beat_Interval;
  logic       Phase_Err;

  spo2_window_stats #(
    .WIN_LOG2 (2),
    .HYST     (8),
    .IBI_MAX  (255)
  ) dut (
    .CLK           (CLK),
    .rst           (rst),
    .Enable        (Enable),
    .LED_RED       (LED_RED),
    .LED_IR        (LED_IR),
    .RED_ADC_Value (RED_ADC_Value),
    .IR_ADC_Value  (IR_ADC_Value),
    .RED_DC        (RED_DC),
    .RED_AC        (RED_AC),
    .IR_DC         (IR_DC),
    .IR_AC         (IR_AC),
    .Stats_Valid   (Stats_Valid),
    .Beat          (Beat),
    .Beat_Interval (Beat_Interval),
    .Phase_Err     (Phase_Err)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int sv_count = 0;
  int beat_count = 0;

  always @(negedge CLK) begin
    if (Stats_Valid === 1'b1) sv_count++;
    if (Beat === 1'b1) beat_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic red_phase(input logic [7:0] r);
    RED_ADC_Value = r;
    LED_RED = 1'b1;
    @(negedge CLK);
    LED_RED = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  // Returns Stats_Valid and Beat as seen in the cycle after the IR fall.
  task automatic ir_phase(input logic [7:0] v, output logic sv, output logic bt);
    IR_ADC_Value = v;
    LED_IR = 1'b1;
    @(negedge CLK);
    LED_IR = 1'b0;
    @(negedge CLK);
    sv = Stats_Valid;
    bt = Beat;
    @(negedge CLK);
  endtask

  task automatic send_pair(input logic [7:0] r, input logic [7:0] i,
                           output logic sv, output logic bt);
    red_phase(r);
    ir_phase(i, sv, bt);
  endtask

  task automatic check_stats(input string tag, input logic [7:0] rdc, input logic [7:0] rac,
                             input logic [7:0] idc, input logic [7:0] iac);
    check({tag, "_red_dc"}, RED_DC, rdc);
    check({tag, "_red_ac"}, RED_AC, rac);
    check({tag, "_ir_dc"},  IR_DC,  idc);
    check({tag, "_ir_ac"},  IR_AC,  iac);
  endtask

  initial begin
    logic       sv;
    logic       bt;
    int         base;
    logic [7:0] t1_red [4];
    logic [7:0] beat_ir [24];

    t1_red = '{8'd100, 8'd120, 8'd140, 8'd160};
    for (int k = 0; k < 24; k++) beat_ir[k] = 8'd128;
    beat_ir[0]  = 8'd115; beat_ir[1]  = 8'd140; beat_ir[2]  = 8'd128; beat_ir[3]  = 8'd129;
    beat_ir[4]  = 8'd125; beat_ir[5]  = 8'd135; beat_ir[6]  = 8'd128; beat_ir[7]  = 8'd124;
    beat_ir[20] = 8'd115; beat_ir[21] = 8'd140; beat_ir[22] = 8'd128; beat_ir[23] = 8'd129;

    rst = 1'b1; Enable = 1'b0; LED_RED = 1'b0; LED_IR = 1'b0;
    RED_ADC_Value = '0; IR_ADC_Value = '0;
    repeat (3) @(negedge CLK);

    // Reset state
    check_stats("rst", 0, 0, 0, 0);
    check("rst_stats_valid", Stats_Valid, 0);
    check("rst_beat", Beat, 0);
    check("rst_beat_interval", Beat_Interval, 0);
    check("rst_phase_err", Phase_Err, 0);

    rst = 1'b0; Enable = 1'b1;
    @(negedge CLK);

    // Basic window: RED 100..160, IR flat 50
    base = sv_count;
    for (int p = 0; p < 4; p++) begin
      send_pair(t1_red[p], 8'd50, sv, bt);
      check($sformatf("t1_sv_p%0d", p), sv, (p == 3));
    end
    check_stats("t1", 130, 60, 50, 0);
    check("t1_sv_low_after", Stats_Valid, 0);
    check("t1_sv_count", sv_count - base, 1);

    // Full-scale samples over three back-to-back windows
    base = sv_count;
    for (int w = 0; w < 3; w++) begin
      for (int p = 0; p < 4; p++) begin
        send_pair(8'd255, 8'd255, sv, bt);
        check($sformatf("t2_sv_w%0d_p%0d", w, p), sv, (p == 3));
      end
      check_stats($sformatf("t2_w%0d", w), 255, 0, 255, 0);
    end
    check("t2_sv_count", sv_count - base, 3);

    // Enable drop discards a partial window and holds the last outputs
    send_pair(8'd200, 8'd200, sv, bt);
    send_pair(8'd200, 8'd200, sv, bt);
    Enable = 1'b0;
    repeat (3) @(negedge CLK);
    check_stats("t3_hold", 255, 0, 255, 0);
    check("t3_sv_idle", Stats_Valid, 0);
    Enable = 1'b1;
    @(negedge CLK);
    for (int p = 0; p < 4; p++) begin
      send_pair(8'd10, 8'd10, sv, bt);
      check($sformatf("t3_sv_p%0d", p), sv, (p == 3));
      if (p == 2) check("t3_held_before_report", RED_DC, 255);
    end
    check_stats("t3", 10, 0, 10, 0);

    // Phase clash while a RED sample is waiting for its IR partner
    send_pair(8'd20, 8'd30, sv, bt);
    check("t4_sv_p0", sv, 0);
    send_pair(8'd20, 8'd30, sv, bt);
    check("t4_sv_p1", sv, 0);
    red_phase(8'd20);
    RED_ADC_Value = 8'd250; IR_ADC_Value = 8'd250;
    LED_RED = 1'b1; LED_IR = 1'b1;
    @(negedge CLK);
    LED_RED = 1'b0; LED_IR = 1'b0;
    @(negedge CLK);
    check("t4_phase_err_set", Phase_Err, 1);
    check("t4_sv_clash", Stats_Valid, 0);
    @(negedge CLK);
    ir_phase(8'd30, sv, bt);
    check("t4_sv_p2", sv, 0);
    send_pair(8'd20, 8'd30, sv, bt);
    check("t4_sv_p3", sv, 1);
    check_stats("t4", 20, 0, 30, 0);
    check("t4_phase_err_sticky", Phase_Err, 1);

    // Beat detector around IR_DC=128 (thresholds 120/136)
    for (int p = 0; p < 4; p++) send_pair(8'd100, 8'd128, sv, bt);
    check("t5_ir_dc_setup", IR_DC, 128);
    check("t5_no_beat_before", beat_count, 0);
    base = beat_count;
    for (int p = 0; p < 24; p++) begin
      send_pair(8'd100, beat_ir[p], sv, bt);
      check($sformatf("t5_beat_p%0d", p), bt, (p == 1 || p == 21));
      if (p == 1) check("t5_first_interval_kept", Beat_Interval, 0);
      if (p == 7) check("t5_dc_after_swing", IR_DC, 128);
    end
    check("t5_beat_interval", Beat_Interval, 20);
    check("t5_beat_count", beat_count - base, 2);

    // Two REDs, one IR, then an orphan IR
    red_phase(8'd90);
    red_phase(8'd60);
    ir_phase(8'd125, sv, bt);
    check("t6_sv_p0", sv, 0);
    ir_phase(8'd130, sv, bt);
    check("t6_sv_orphan", sv, 0);
    for (int p = 1; p < 4; p++) begin
      send_pair(8'd60, 8'd125, sv, bt);
      check($sformatf("t6_sv_p%0d", p), sv, (p == 3));
    end
    check_stats("t6", 60, 0, 125, 0);

    // Reset mid-window
    send_pair(8'd77, 8'd77, sv, bt);
    send_pair(8'd77, 8'd77, sv, bt);
    rst = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check_stats("t7_rst", 0, 0, 0, 0);
    check("t7_phase_err_cleared", Phase_Err, 0);
    check("t7_beat_interval_cleared", Beat_Interval, 0);
    check("t7_sv", Stats_Valid, 0);
    rst = 1'b0;
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
